// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read/two-write register file with a load-busy scoreboard.
// Generates a stall signal when an operand, or a load destination, still has a load outstanding.
module reg_file_sb #(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter bit BLANK_A = 1'b1,
    parameter bit BLANK_B = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         wr_en,
    input  logic [D-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         ld_valid,
    input  logic [D-1:0] ld_addr,
    input  logic [W-1:0] ld_data,
    input  logic         lock_en,
    input  logic [D-1:0] lock_addr,
    input  logic [D-1:0] rd_addrA,
    input  logic [D-1:0] rd_addrB,
    input  logic         rd_enA,
    input  logic         rd_enB,
    output logic [W-1:0] rd_dataA,
    output logic [W-1:0] rd_dataB,
    output logic         busy_A,
    output logic         busy_B,
    output logic         stall,
    output logic [D:0]   pending
);
    localparam int N = 2**D;

    logic [W-1:0] regs [N];
    logic [N-1:0] busy, busy_n;
    logic [D:0]   cnt;

    // The ALU write is younger than a returning load, so it wins the forward.
    function automatic logic [W-1:0] rd(input logic [D-1:0] a, input logic blank);
        rd = (blank && a == '0) ? '0 :
             (BYPASS && wr_en && wr_addr == a) ? wr_data :
             (BYPASS && ld_valid && ld_addr == a) ? ld_data : regs[a];
    endfunction

    function automatic logic busy_rd(input logic [D-1:0] a);
        busy_rd = busy[a] & ~(BYPASS && ((ld_valid && ld_addr == a) || (wr_en && wr_addr == a)));
    endfunction

    assign rd_dataA = rd(rd_addrA, BLANK_A);
    assign rd_dataB = rd(rd_addrB, BLANK_B);
    assign busy_A   = busy_rd(rd_addrA);
    assign busy_B   = busy_rd(rd_addrB);
    assign stall    = (rd_enA & busy_A) | (rd_enB & busy_B) | (lock_en & busy_rd(lock_addr));

    always_comb begin
        busy_n = busy;
        if (ld_valid) busy_n[ld_addr] = 1'b0;
        if (wr_en) busy_n[wr_addr] = 1'b0;
        if (lock_en) busy_n[lock_addr] = 1'b1;
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + {{D{1'b0}}, busy_n[i]};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            busy    <= '0;
            pending <= '0;
        end else begin
            if (ld_valid) regs[ld_addr] <= ld_data;
            if (wr_en) regs[wr_addr] <= wr_data;
            busy    <= busy_n;
            pending <= cnt;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb with an expected-value queue.
// A second instance built with BYPASS=0 shares the same stimulus.
module tb_reg_file_sb;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       wr_en, ld_valid, lock_en, rd_enA, rd_enB;
    logic [3:0] wr_addr, ld_addr, lock_addr, rd_addrA, rd_addrB;
    logic [7:0] wr_data, ld_data;
    logic [7:0] rd_dataA, rd_dataB, rd_dataA_0, rd_dataB_0;
    logic       busy_A, busy_B, stall, busy_A_0, busy_B_0, stall_0;
    logic [4:0] pending, pending_0;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    reg_file_sb dut (
        .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .lock_en(lock_en),
        .lock_addr(lock_addr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .rd_enA(rd_enA),
        .rd_enB(rd_enB), .rd_dataA(rd_dataA), .rd_dataB(rd_dataB), .busy_A(busy_A),
        .busy_B(busy_B), .stall(stall), .pending(pending)
    );

    reg_file_sb #(.BYPASS(1'b0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .lock_en(lock_en),
        .lock_addr(lock_addr), .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .rd_enA(rd_enA),
        .rd_enB(rd_enB), .rd_dataA(rd_dataA_0), .rd_dataB(rd_dataB_0), .busy_A(busy_A_0),
        .busy_B(busy_B_0), .stall(stall_0), .pending(pending_0)
    );

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_q.push_back('{tag, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL queue_empty observed=%0h required=entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; ld_valid = 0; lock_en = 0;
    endtask

    initial begin
        RST_N = 0; idle(); rd_enA = 0; rd_enB = 0;
        wr_addr = 0; ld_addr = 0; lock_addr = 0; rd_addrA = 0; rd_addrB = 3;
        wr_data = 0; ld_data = 0;
        #2;
        expect_v("rst_pending", 0); chk(pending);
        expect_v("rst_stall", 0);   chk(stall);
        expect_v("rst_rdB", 0);     chk(rd_dataB);
        @(negedge CLK); RST_N = 1;
        step();
        wr_en = 1; wr_addr = 3; wr_data = 8'h5A;
        step(); idle(); rd_addrA = 3; #1;
        expect_v("r3_read", 8'h5A); chk(rd_dataA);
        wr_en = 1; wr_addr = 0; wr_data = 8'h77;
        step(); idle(); rd_addrA = 0; rd_addrB = 0; #1;
        expect_v("blankA_r0", 0);    chk(rd_dataA);
        expect_v("portB_r0", 8'h77); chk(rd_dataB);
        wr_en = 1; wr_addr = 5; wr_data = 8'h12;
        step();
        wr_data = 8'hC3; rd_addrB = 5; #1;
        expect_v("bypassB", 8'hC3);    chk(rd_dataB);
        expect_v("nobypassB", 8'h12);  chk(rd_dataB_0);
        step(); idle(); #1;
        expect_v("nobypassB_after", 8'hC3); chk(rd_dataB_0);
        lock_en = 1; lock_addr = 7;
        step(); idle(); rd_enA = 1; rd_addrA = 7; #1;
        expect_v("busyA_r7", 1);  chk(busy_A);
        expect_v("stall_r7", 1);  chk(stall);
        expect_v("pending_1", 1); chk(pending);
        ld_valid = 1; ld_addr = 7; ld_data = 8'h11; #1;
        expect_v("ld_stall_bypass", 0); chk(stall);
        expect_v("ld_dataA_bypass", 8'h11); chk(rd_dataA);
        expect_v("ld_stall_nobypass", 1); chk(stall_0);
        expect_v("ld_dataA_nobypass", 0); chk(rd_dataA_0);
        step(); idle(); #1;
        expect_v("pending_0", 0); chk(pending);
        expect_v("r7_loaded", 8'h11); chk(rd_dataA);
        rd_enA = 0;
        wr_en = 1; wr_addr = 2; wr_data = 8'hAA;
        ld_valid = 1; ld_addr = 2; ld_data = 8'h55; rd_addrA = 2; #1;
        expect_v("prio_bypass", 8'hAA); chk(rd_dataA);
        step(); idle(); #1;
        expect_v("prio_r2", 8'hAA); chk(rd_dataA);
        wr_en = 1; wr_addr = 2; wr_data = 8'h3C;
        ld_valid = 1; ld_addr = 4; ld_data = 8'h4D;
        step(); idle(); rd_addrB = 4; #1;
        expect_v("dual_r2", 8'h3C); chk(rd_dataA);
        expect_v("dual_r4", 8'h4D); chk(rd_dataB);
        lock_en = 1; lock_addr = 6;
        step();
        ld_valid = 1; ld_addr = 6; ld_data = 8'h66;
        step(); idle(); rd_addrA = 6; #1;
        expect_v("set_wins_busy", 1); chk(busy_A);
        expect_v("set_wins_pend", 1); chk(pending);
        lock_en = 1; lock_addr = 8;
        step(); idle();
        wr_en = 1; wr_addr = 8; wr_data = 8'h99;
        step(); idle(); rd_addrB = 8; #1;
        expect_v("wr_clears_busy", 0); chk(busy_B);
        expect_v("wr_clears_pend", 1); chk(pending);
        for (int i = 0; i < 16; i++) begin
            lock_en = 1; lock_addr = i[3:0];
            step();
        end
        idle(); #1;
        expect_v("pending_16", 16); chk(pending);
        lock_en = 1; lock_addr = 3; #1;
        expect_v("lock_busy_stall", 1); chk(stall);
        ld_valid = 1; ld_addr = 3; ld_data = 8'h33; #1;
        expect_v("lock_ld_stall", 0); chk(stall);
        idle();
        @(negedge CLK); RST_N = 0; #2; RST_N = 1;
        step();
        lock_en = 1; lock_addr = 1;
        step(); lock_addr = 9;
        step(); idle(); rd_enA = 1; rd_addrA = 1; rd_addrB = 2; #1;
        expect_v("pre_rst_pend", 2); chk(pending);
        expect_v("pre_rst_stall", 1); chk(stall);
        #2; RST_N = 0; #1;
        expect_v("rst_async_pend", 0); chk(pending);
        expect_v("rst_async_stall", 0); chk(stall);
        expect_v("rst_async_rdB", 0); chk(rd_dataB);
        @(negedge CLK); RST_N = 1;
        step();
        ld_valid = 1; ld_addr = 1; ld_data = 8'h21;
        step(); idle(); #1;
        expect_v("post_rst_ld", 8'h21); chk(rd_dataA);
        expect_v("post_rst_busy", 0); chk(busy_A);
        expect_v("post_rst_pend", 0); chk(pending);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
